dct_butterfly_stage: RTL and testbench
======================================

DCT_BUTTERFLY_STAGE -- requirements
Module: dct_butterfly_stage

Interface
REQ-001 Parameter M, default 1: number of butterfly lanes per beat.
REQ-002 Parameter W, default 18: signed sample width.
REQ-003 Parameter CW, default 18: signed coefficient width.
REQ-004 Parameter COEFF, default 256: signed coefficient value, Q(CW-FRAC).FRAC.
REQ-005 Parameter FRAC, default 8: coefficient fractional bits.
REQ-006 Parameter ROUND, default 1: 1 = round-half-up on product shift, 0 = arithmetic truncate.
REQ-007 Parameter SAT, default 1: 1 = saturate outputs to W bits, 0 = wrap.
REQ-008 clk  in  1  clock; reset  in  1  synchronous, active-high reset.
REQ-009 in_valid  in  1  input beat valid; in_ready  out  1  block accepts beat.
REQ-010 top_in_flat, bot_in_flat  in  M*W  signed lanes; lane k at bits [k*W +: W].
REQ-011 bypass_in  in  1  per-beat mode; 1 = pass top/bot through unmodified.
REQ-012 out_valid  out  1; out_ready  in  1  downstream handshake.
REQ-013 top_out_flat, bot_out_flat  out  M*W  signed result lanes.
REQ-014 sat_out  out  1  at least one lane of this output beat clipped.
REQ-015 clear_cnt  in  1  zeroes sat_count; sat_count  out  16  saturating count of clipped beats.

Function
REQ-016 Lane i pairs top[i] with b = bot[M-1-i] (mirrored).
REQ-017 s = top[i] - b, computed in W+1 bits with no loss.
REQ-018 p = b * COEFF, full W+CW bits; pr = (p + 2^(FRAC-1)) >>> FRAC if ROUND, else p >>> FRAC.
REQ-019 top_out[i] = s + pr, bot_out[i] = s - pr, computed in W+CW+1 bits, then saturated to [-2^(W-1), 2^(W-1)-1] if SAT, else low W bits kept.
REQ-020 With bypass, top_out = top_in, bot_out = bot_in (no mirroring); sat_out = 0.
REQ-021 Two-stage pipeline: S1 registers s, p and bypass; S2 registers rounded/saturated results.
REQ-022 Latency: beat accepted in cycle n appears with out_valid in cycle n+2 when no stall occurs.
REQ-023 Transfer occurs on valid && ready at a rising edge; out data and out_valid are held stable while out_valid && !out_ready.
REQ-024 S2 loads when S2 is empty or out_ready; S1 loads when S1 is empty or S1 advances.
REQ-025 in_ready = !v1 || !v2 || out_ready; combinational path from out_ready is permitted.
REQ-026 Full throughput: one beat per cycle while out_ready is held high; no bubbles, no loss, no duplication under any ready pattern.
REQ-027 sat_count increments by 1 per output transfer with sat_out = 1, holds at 16'hFFFF.
REQ-028 clear_cnt has priority over a simultaneous increment; result is 0.

Reset
REQ-029 While reset is high: v1, v2, out_valid, sat_out = 0; top_out_flat, bot_out_flat = 0; sat_count = 0; in_ready = 0.
REQ-030 Reset mid-operation discards all in-flight beats; first beat accepted after release emerges 2 cycles later.

Structure
REQ-031 Shared package dct_pkg holds the default W/CW/FRAC constants and the saturate-to-W function.
REQ-032 One sub-module, dct_sat_round, performs shift, round and saturation for one lane and is instantiated per lane and output.

Verification
REQ-033 Defaults; top=100, bot=40, out_ready=1 -> after 2 cycles top_out=100, bot_out=20, sat_out=0.
REQ-034 COEFF=181, bot=-3, top=0 -> ROUND=1 gives pr=-2 (top_out=1, bot_out=5); ROUND=0 gives pr=-3 (top_out=0, bot_out=6).
REQ-035 Defaults; top=131071, bot=-131072 -> top_out=131071, bot_out=131071 clipped, sat_out=1, sat_count=1.
REQ-036 M=4, lanes top=1,2,3,4 and bot=10,20,30,40, COEFF=0 -> top_out=-39,-28,-17,-6 (bot mirrored), bot_out equal.
REQ-037 Stream 20 beats, out_ready random 50% -> all beats delivered in order, none dropped or repeated, outputs stable during stalls.
REQ-038 Reset asserted with both stages full -> out_valid=0 next cycle, sat_count=0; new beat after release delivered with 2-cycle latency.

Source files
------------

// File: rtl/dct_pkg.sv
// Shared defaults and the saturate-to-width helper for the DCT butterfly datapath.
package dct_pkg;

    localparam int unsigned DefW    = 18;
    localparam int unsigned DefCw   = 18;
    localparam int unsigned DefFrac = 8;

    // Widest intermediate the helper handles; W + CW + 2 must not exceed this.
    localparam int unsigned WideMax = 64;

    typedef logic signed [WideMax-1:0] wide_t;

    // Clamp x into the signed range representable in w bits.
    function automatic wide_t sat_to_w(input wide_t x, input int unsigned w);
        wide_t hi;
        wide_t lo;
        hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
        lo = -(wide_t'(1) <<< (w - 1));
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/dct_sat_round.sv
// One butterfly output: shift/round the product, add or subtract it from s, then clamp or wrap.
module dct_sat_round
    import dct_pkg::*;
#(
    parameter int unsigned W     = DefW,
    parameter int unsigned CW    = DefCw,
    parameter int unsigned FRAC  = DefFrac,
    parameter int unsigned ROUND = 1,
    parameter int unsigned SAT   = 1,
    parameter int unsigned SUB   = 0
) (
    input  logic signed [W:0]      s_i,
    input  logic signed [W+CW-1:0] p_i,
    output logic        [W-1:0]    y_o,
    output logic                   clip_o
);

    localparam int unsigned PW    = W + CW + 1;
    localparam int unsigned SW    = W + CW + 2;
    localparam int unsigned RndSh = (FRAC == 0) ? 0 : FRAC - 1;
    localparam logic signed [PW-1:0] RndC =
        (ROUND != 0 && FRAC != 0) ? (PW'(1) <<< RndSh) : '0;

    logic signed [PW-1:0] p_rnd;
    logic signed [PW-1:0] pr;
    logic signed [SW-1:0] sum;
    wide_t                sum_w;
    wide_t                sat_w;

    always_comb begin
        p_rnd = PW'(p_i) + RndC;
        pr    = p_rnd >>> FRAC;
        if (SUB != 0) begin
            sum = SW'(s_i) - SW'(pr);
        end else begin
            sum = SW'(s_i) + SW'(pr);
        end
        sum_w = wide_t'(sum);
        sat_w = sat_to_w(sum_w, W);
        if (SAT != 0) begin
            y_o    = sat_w[W-1:0];
            clip_o = (sat_w != sum_w);
        end else begin
            y_o    = sum[W-1:0];
            clip_o = 1'b0;
        end
    end

endmodule

// File: rtl/dct_butterfly_stage.sv
// Two-stage pipelined, mirrored-lane DCT butterfly with valid/ready flow control
// and a saturating count of clipped output beats.
module dct_butterfly_stage
    import dct_pkg::*;
#(
    parameter int unsigned M     = 1,
    parameter int unsigned W     = DefW,
    parameter int unsigned CW    = DefCw,
    parameter int          COEFF = 256,
    parameter int unsigned FRAC  = DefFrac,
    parameter int unsigned ROUND = 1,
    parameter int unsigned SAT   = 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [M*W-1:0] top_in_flat,
    input  logic [M*W-1:0] bot_in_flat,
    input  logic           bypass_in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [M*W-1:0] top_out_flat,
    output logic [M*W-1:0] bot_out_flat,
    output logic           sat_out,
    input  logic           clear_cnt,
    output logic [15:0]    sat_count
);

    localparam int unsigned SW = W + 1;
    localparam int unsigned PW = W + CW;
    localparam logic signed [CW-1:0] CoeffC = CW'(COEFF);

    logic                  v1_q, v1_d, v2_q, v2_d;
    logic                  byp1_q, byp1_d;
    logic [M-1:0][SW-1:0]  s1_q, s1_d, s_new;
    logic [M-1:0][PW-1:0]  p1_q, p1_d, p_new;
    logic [M*W-1:0]        top2_q, top2_d, bot2_q, bot2_d;
    logic                  sat2_q, sat2_d;
    logic [15:0]           cnt_q, cnt_d;
    logic                  load1, load2;

    logic [M*W-1:0]        y_add, y_sub;
    logic [M-1:0]          c_add, c_sub;

    assign load2    = !v2_q || out_ready;
    assign load1    = !v1_q || load2;
    assign in_ready = !reset && load1;

    // Lane front end. In bypass, s/p carry the raw unmirrored top/bot samples instead.
    always_comb begin
        logic signed [W-1:0] top_l;
        logic signed [W-1:0] bot_l;
        logic signed [W-1:0] bot_m;
        for (int i = 0; i < M; i++) begin
            top_l = $signed(top_in_flat[i*W +: W]);
            bot_l = $signed(bot_in_flat[i*W +: W]);
            bot_m = $signed(bot_in_flat[(M-1-i)*W +: W]);
            if (bypass_in) begin
                s_new[i] = SW'(top_l);
                p_new[i] = PW'(bot_l);
            end else begin
                s_new[i] = SW'(top_l) - SW'(bot_m);
                p_new[i] = PW'(bot_m) * PW'(CoeffC);
            end
        end
    end

    always_comb begin
        v1_d   = v1_q;
        byp1_d = byp1_q;
        s1_d   = s1_q;
        p1_d   = p1_q;
        if (load1) begin
            v1_d = in_valid;
            if (in_valid) begin
                byp1_d = bypass_in;
                s1_d   = s_new;
                p1_d   = p_new;
            end
        end
    end

    for (genvar g = 0; g < M; g++) begin : g_lane
        dct_sat_round #(
            .W     (W),
            .CW    (CW),
            .FRAC  (FRAC),
            .ROUND (ROUND),
            .SAT   (SAT),
            .SUB   (0)
        ) u_add (
            .s_i    ($signed(s1_q[g])),
            .p_i    ($signed(p1_q[g])),
            .y_o    (y_add[g*W +: W]),
            .clip_o (c_add[g])
        );

        dct_sat_round #(
            .W     (W),
            .CW    (CW),
            .FRAC  (FRAC),
            .ROUND (ROUND),
            .SAT   (SAT),
            .SUB   (1)
        ) u_sub (
            .s_i    ($signed(s1_q[g])),
            .p_i    ($signed(p1_q[g])),
            .y_o    (y_sub[g*W +: W]),
            .clip_o (c_sub[g])
        );
    end

    always_comb begin
        v2_d   = v2_q;
        top2_d = top2_q;
        bot2_d = bot2_q;
        sat2_d = sat2_q;
        if (load2) begin
            v2_d   = v1_q;
            sat2_d = 1'b0;
            if (v1_q) begin
                if (byp1_q) begin
                    for (int i = 0; i < M; i++) begin
                        top2_d[i*W +: W] = s1_q[i][W-1:0];
                        bot2_d[i*W +: W] = p1_q[i][W-1:0];
                    end
                end else begin
                    top2_d = y_add;
                    bot2_d = y_sub;
                    sat2_d = |(c_add | c_sub);
                end
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clear_cnt) begin
            cnt_d = '0;
        end else if (v2_q && out_ready && sat2_q && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            byp1_q <= 1'b0;
            s1_q   <= '0;
            p1_q   <= '0;
            top2_q <= '0;
            bot2_q <= '0;
            sat2_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            v1_q   <= v1_d;
            v2_q   <= v2_d;
            byp1_q <= byp1_d;
            s1_q   <= s1_d;
            p1_q   <= p1_d;
            top2_q <= top2_d;
            bot2_q <= bot2_d;
            sat2_q <= sat2_d;
            cnt_q  <= cnt_d;
        end
    end

    assign out_valid    = v2_q;
    assign top_out_flat = top2_q;
    assign bot_out_flat = bot2_q;
    assign sat_out      = sat2_q;
    assign sat_count    = cnt_q;

endmodule

// File: tb/tb_dct_butterfly_stage.sv
// Directed bench for dct_butterfly_stage across default, rounding, truncating and 4-lane builds.
module tb_dct_butterfly_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        out_ready;
    logic        bypass_in;
    logic        clear_cnt;
    logic [17:0] top_in, bot_in;
    logic [71:0] m4_tin, m4_bin;

    logic        d_rdy, d_vld, d_sat;
    logic [17:0] d_top, d_bot;
    logic [15:0] d_cnt;
    logic        r1_rdy, r1_vld, r1_sat;
    logic [17:0] r1_top, r1_bot;
    logic [15:0] r1_cnt;
    logic        r0_rdy, r0_vld, r0_sat;
    logic [17:0] r0_top, r0_bot;
    logic [15:0] r0_cnt;
    logic        m4_rdy, m4_vld, m4_sat;
    logic [71:0] m4_top, m4_bot;
    logic [15:0] m4_cnt;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dct_butterfly_stage u_def (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(d_rdy),
        .top_in_flat(top_in), .bot_in_flat(bot_in), .bypass_in(bypass_in),
        .out_valid(d_vld), .out_ready(out_ready), .top_out_flat(d_top),
        .bot_out_flat(d_bot), .sat_out(d_sat), .clear_cnt(clear_cnt), .sat_count(d_cnt)
    );

    dct_butterfly_stage #(.COEFF(181), .ROUND(1)) u_r1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(r1_rdy),
        .top_in_flat(top_in), .bot_in_flat(bot_in), .bypass_in(bypass_in),
        .out_valid(r1_vld), .out_ready(out_ready), .top_out_flat(r1_top),
        .bot_out_flat(r1_bot), .sat_out(r1_sat), .clear_cnt(clear_cnt), .sat_count(r1_cnt)
    );

    dct_butterfly_stage #(.COEFF(181), .ROUND(0)) u_r0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(r0_rdy),
        .top_in_flat(top_in), .bot_in_flat(bot_in), .bypass_in(bypass_in),
        .out_valid(r0_vld), .out_ready(out_ready), .top_out_flat(r0_top),
        .bot_out_flat(r0_bot), .sat_out(r0_sat), .clear_cnt(clear_cnt), .sat_count(r0_cnt)
    );

    dct_butterfly_stage #(.M(4), .COEFF(0)) u_m4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(m4_rdy),
        .top_in_flat(m4_tin), .bot_in_flat(m4_bin), .bypass_in(bypass_in),
        .out_valid(m4_vld), .out_ready(out_ready), .top_out_flat(m4_top),
        .bot_out_flat(m4_bot), .sat_out(m4_sat), .clear_cnt(clear_cnt), .sat_count(m4_cnt)
    );

    function automatic logic [17:0] s18(input int v);
        logic [31:0] t;
        t = v;
        return t[17:0];
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with out_ready high; returns at the negedge where the beat is on the output.
    task automatic send1(input int t, input int b, input logic byp);
        top_in    = s18(t);
        bot_in    = s18(b);
        bypass_in = byp;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        bypass_in = 1'b0;
        chk("lat1", d_vld, 1'b0);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int  sent, rcv;
        logic hold_pend, acc_in;
        logic [17:0] held_t, held_b;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; bypass_in = 1'b0; clear_cnt = 1'b0;
        top_in = '0; bot_in = '0; m4_tin = '0; m4_bin = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rdy", d_rdy, 1'b0);
        chk("rst_vld", d_vld, 1'b0);
        chk("rst_top", d_top, 18'd0);
        chk("rst_bot", d_bot, 18'd0);
        chk("rst_sat", d_sat, 1'b0);
        chk("rst_cnt", d_cnt, 16'd0);
        reset = 1'b0;
        out_ready = 1'b1;

        // Back-to-back beats: (100,40) then (0,-3)
        top_in = s18(100); bot_in = s18(40); in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("lat_a", d_vld, 1'b0);
        top_in = s18(0); bot_in = s18(-3);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("a_vld", d_vld, 1'b1);
        chk("a_top", d_top, s18(100));
        chk("a_bot", d_bot, s18(20));
        chk("a_sat", d_sat, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("r1_top", r1_top, s18(1));
        chk("r1_bot", r1_bot, s18(5));
        chk("r0_top", r0_top, s18(0));
        chk("r0_bot", r0_bot, s18(6));
        chk("b_top", d_top, s18(0));
        chk("b_bot", d_bot, s18(6));

        // Saturation and counter
        send1(131071, -131072, 1'b0);
        chk("sat_top", d_top, s18(131071));
        chk("sat_bot", d_bot, s18(131071));
        chk("sat_flag", d_sat, 1'b1);
        @(posedge clk);
        @(negedge clk);
        chk("cnt_one", d_cnt, 16'd1);

        clear_cnt = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clear_cnt = 1'b0;
        chk("cnt_clr", d_cnt, 16'd0);

        send1(131071, -131072, 1'b0);
        clear_cnt = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clear_cnt = 1'b0;
        chk("cnt_prio", d_cnt, 16'd0);

        // Bypass: raw values, no mirroring, no clip flag
        m4_tin = {s18(4), s18(3), s18(2), s18(1)};
        m4_bin = {s18(40), s18(30), s18(20), s18(10)};
        send1(131071, -131072, 1'b1);
        chk("byp_top", d_top, s18(131071));
        chk("byp_bot", d_bot, s18(-131072));
        chk("byp_sat", d_sat, 1'b0);
        chk("byp_m4t", m4_top, {56'd0, s18(4), s18(3), s18(2), s18(1)});
        chk("byp_m4b", m4_bot, {56'd0, s18(40), s18(30), s18(20), s18(10)});
        @(posedge clk);
        @(negedge clk);
        chk("byp_cnt", d_cnt, 16'd0);

        // Four mirrored lanes, zero coefficient
        send1(0, 0, 1'b0);
        chk("m4_top", m4_top, {56'd0, s18(-6), s18(-17), s18(-28), s18(-39)});
        chk("m4_bot", m4_bot, {56'd0, s18(-6), s18(-17), s18(-28), s18(-39)});

        send1(131071, -131072, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("cnt_again", d_cnt, 16'd1);

        // Stream of 20 beats under random back-pressure: beat k has top=7k+3, bot=k-5
        sent = 0; rcv = 0; hold_pend = 1'b0; held_t = '0; held_b = '0;
        for (int cyc = 0; cyc < 400 && rcv < 20; cyc++) begin
            @(negedge clk);
            if (hold_pend) begin
                chk("hold_vld", d_vld, 1'b1);
                chk("hold_top", d_top, held_t);
                chk("hold_bot", d_bot, held_b);
            end
            in_valid  = (sent < 20);
            top_in    = s18(sent * 7 + 3);
            bot_in    = s18(sent - 5);
            out_ready = 1'($urandom_range(0, 1));
            #1;
            acc_in = in_valid && d_rdy;
            if (d_vld && out_ready) begin
                chk("strm_top", d_top, s18(rcv * 7 + 3));
                chk("strm_bot", d_bot, s18(rcv * 5 + 13));
                rcv++;
            end
            hold_pend = d_vld && !out_ready;
            held_t    = d_top;
            held_b    = d_bot;
            @(posedge clk);
            if (acc_in) sent++;
        end
        in_valid = 1'b0;
        chk("strm_cnt", rcv, 20);

        // Fill both stages, then reset mid-flight
        @(negedge clk);
        out_ready = 1'b0;
        top_in = s18(1); bot_in = s18(0); in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        top_in = s18(2);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("full_vld", d_vld, 1'b1);
        chk("full_rdy", d_rdy, 1'b0);
        chk("full_cnt", d_cnt, 16'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_vld", d_vld, 1'b0);
        chk("mid_cnt", d_cnt, 16'd0);
        chk("mid_rdy", d_rdy, 1'b0);
        chk("mid_top", d_top, 18'd0);
        reset = 1'b0;
        out_ready = 1'b1;
        send1(77, 7, 1'b0);
        chk("post_vld", d_vld, 1'b1);
        chk("post_top", d_top, s18(77));
        chk("post_bot", d_bot, s18(63));
        @(posedge clk);
        @(negedge clk);
        chk("post_empty", d_vld, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
